// File: rtl/spi_accel_responder.sv
// SPI mode-3 target emulating an accelerometer: 64x8 register file,
// command decode, burst reads/writes and sample-port loading of axis data.
module spi_accel_responder #(
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter logic [7:0]  BW_RATE_RST = 8'h0A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        sys_clock,
    input  logic        reset_n,
    input  logic        SCL,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        miso_oe,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        int1,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned SW    = 16;
    localparam int unsigned NREGS = 64;

    localparam logic [AW-1:0] ADDR_DEVID = 6'h00;
    localparam logic [AW-1:0] ADDR_BW    = 6'h2C;
    localparam logic [AW-1:0] ADDR_X0    = 6'h32;
    localparam logic [AW-1:0] ADDR_X1    = 6'h33;
    localparam logic [AW-1:0] ADDR_Y0    = 6'h34;
    localparam logic [AW-1:0] ADDR_Y1    = 6'h35;
    localparam logic [AW-1:0] ADDR_Z0    = 6'h36;
    localparam logic [AW-1:0] ADDR_Z1    = 6'h37;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, cs_sync_q, mosi_sync_q;
    logic scl_s, cs_s, mosi_s;
    logic scl_prev_q, cs_prev_q;
    logic scl_rise_q, scl_fall_q, cs_rise_q, cs_fall_q;

    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] tx_q, tx_d;
    logic          rw_q, rw_d, mb_q, mb_d;
    logic [AW-1:0] addr_q, addr_d, next_addr;
    logic          miso_q, miso_d;
    logic          oe_q, busy_q;
    logic          int1_q, int1_d, int1_clr;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          spi_we;
    logic [AW-1:0] spi_waddr;
    logic [DW-1:0] spi_wdata;

    logic          pend_valid_q, pend_valid_d;
    logic [SW-1:0] pend_x_q, pend_y_q, pend_z_q, pend_x_d, pend_y_d, pend_z_d;
    logic          axis_ld, in_txn;
    logic [SW-1:0] axis_x, axis_y, axis_z;

    logic [DW-1:0] regs_q [NREGS];

    function automatic logic is_ro(input logic [AW-1:0] a);
        return (a == ADDR_DEVID) || (a >= 6'h30 && a <= 6'h39);
    endfunction

    assign scl_s  = scl_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Input synchronizers and registered edge pulses (acted on one cycle later)
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q  <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            scl_prev_q  <= 1'b1;
            cs_prev_q   <= 1'b1;
            scl_rise_q  <= 1'b0;
            scl_fall_q  <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            scl_prev_q  <= scl_s;
            cs_prev_q   <= cs_s;
            scl_rise_q  <= scl_s & ~scl_prev_q;
            scl_fall_q  <= ~scl_s & scl_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
            busy_q      <= ~cs_s;
            oe_q        <= ~cs_s;
        end
    end

    // Transaction FSM: command decode, shift in/out, write and read-advance
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        mb_d        = mb_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        spi_we      = 1'b0;
        spi_waddr   = addr_q;
        spi_wdata   = shift_q;
        int1_clr    = 1'b0;
        next_addr   = mb_q ? addr_q + 6'd1 : addr_q;

        if (cs_rise_q) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                        shift_d   = '0;
                        miso_d    = 1'b0;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (scl_rise_q) begin
                        shift_d   = {shift_q[DW-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = shift_d[7];
                            mb_d    = shift_d[6];
                            addr_d  = shift_d[AW-1:0];
                            state_d = ST_DATA;
                            if (shift_d[7]) begin
                                tx_d = regs_q[shift_d[AW-1:0]];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_fall_q && rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[DW-2:0], 1'b0};
                    end
                    if (scl_rise_q) begin
                        shift_d   = {shift_q[DW-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = next_addr;
                            if (rw_q) begin
                                tx_d = regs_q[next_addr];
                                if (addr_q == ADDR_Z1) begin
                                    int1_clr = 1'b1;
                                end
                            end else if (!is_ro(addr_q)) begin
                                spi_we      = 1'b1;
                                spi_wdata   = shift_d;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = shift_d;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sample port: load axis regs when idle, otherwise hold latest until CS rises
    always_comb begin
        in_txn       = busy_q || (state_q != ST_IDLE);
        axis_ld      = 1'b0;
        axis_x       = sample_x;
        axis_y       = sample_y;
        axis_z       = sample_z;
        pend_valid_d = pend_valid_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_z_d     = pend_z_q;

        if (sample_valid && (!in_txn || cs_rise_q)) begin
            axis_ld      = 1'b1;
            pend_valid_d = 1'b0;
        end else if (sample_valid) begin
            pend_valid_d = 1'b1;
            pend_x_d     = sample_x;
            pend_y_d     = sample_y;
            pend_z_d     = sample_z;
        end else if (cs_rise_q && pend_valid_q) begin
            axis_ld      = 1'b1;
            axis_x       = pend_x_q;
            axis_y       = pend_y_q;
            axis_z       = pend_z_q;
            pend_valid_d = 1'b0;
        end

        int1_d = axis_ld ? 1'b1 : (int1_clr ? 1'b0 : int1_q);
    end

    // FSM and datapath state registers
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            tx_q         <= '0;
            rw_q         <= 1'b0;
            mb_q         <= 1'b0;
            addr_q       <= '0;
            miso_q       <= 1'b0;
            int1_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_z_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rw_q         <= rw_d;
            mb_q         <= mb_d;
            addr_q       <= addr_d;
            miso_q       <= miso_d;
            int1_q       <= int1_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            pend_valid_q <= pend_valid_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_z_q     <= pend_z_d;
        end
    end

    // Register file: SPI writes (never to read-only space) and axis loads
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q             <= '{default: 8'h00};
            regs_q[ADDR_DEVID] <= DEVID;
            regs_q[ADDR_BW]    <= BW_RATE_RST;
        end else begin
            if (spi_we) begin
                regs_q[spi_waddr] <= spi_wdata;
            end
            if (axis_ld) begin
                regs_q[ADDR_X0] <= axis_x[7:0];
                regs_q[ADDR_X1] <= axis_x[15:8];
                regs_q[ADDR_Y0] <= axis_y[7:0];
                regs_q[ADDR_Y1] <= axis_y[15:8];
                regs_q[ADDR_Z0] <= axis_z[7:0];
                regs_q[ADDR_Z1] <= axis_z[15:8];
            end
        end
    end

    assign MISO      = miso_q;
    assign miso_oe   = oe_q;
    assign busy      = busy_q;
    assign int1      = int1_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Bench for spi_accel_responder: directed cases plus random transactions
// checked against a byte-level register-map model.
module tb_spi_accel_responder;

    localparam int unsigned HALF = 80;

    logic        sys_clock = 1'b0;
    logic        reset_n;
    logic        SCL, CS, MOSI;
    logic        MISO, miso_oe;
    logic        sample_valid;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        int1, wr_strobe, busy;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    spi_accel_responder dut (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .SCL         (SCL),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .miso_oe     (miso_oe),
        .sample_valid(sample_valid),
        .sample_x    (sample_x),
        .sample_y    (sample_y),
        .sample_z    (sample_z),
        .int1        (int1),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #5 sys_clock = ~sys_clock;

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the register map
    logic [7:0]  m_regs [64];
    logic        m_int1;
    int          exp_strobes;
    logic [5:0]  exp_wa;
    logic [7:0]  exp_wd;
    logic        m_pend;
    logic [15:0] m_px, m_py, m_pz;
    logic [7:0]  wbuf [8];

    int strobe_cnt = 0;
    always @(posedge sys_clock) if (wr_strobe === 1'b1) strobe_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ro(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h30 && a <= 6'h39);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[0]  = 8'hE5;
        m_regs[44] = 8'h0A;
        m_int1 = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
        m_pend = 1'b0;
    endtask

    task automatic model_axis(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        m_regs[50] = x[7:0]; m_regs[51] = x[15:8];
        m_regs[52] = y[7:0]; m_regs[53] = y[15:8];
        m_regs[54] = z[7:0]; m_regs[55] = z[15:8];
        m_int1 = 1'b1;
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge sys_clock);
        sample_valid = 1'b1;
        sample_x = x; sample_y = y; sample_z = z;
        @(negedge sys_clock);
        sample_valid = 1'b0;
    endtask

    task automatic sample_idle(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        pulse_sample(x, y, z);
        model_axis(x, y, z);
        repeat (3) @(negedge sys_clock);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            SCL  = 1'b0;
            MOSI = b[i];
            #HALF;
            r[i] = MISO;
            SCL  = 1'b1;
            #HALF;
        end
    endtask

    // Full transaction with model update; optional sample pulse before byte 1
    task automatic do_txn(input bit rw, input bit mb, input logic [5:0] addr, input int n,
                          input bit sample_mid, input logic [15:0] mx, input logic [15:0] my,
                          input logic [15:0] mz);
        logic [5:0] a;
        logic [7:0] rx, d, e;
        a  = addr;
        CS = 1'b0;
        #HALF;
        spi_bits({rw, mb, addr}, 8, rx);
        check_eq("cmd_miso", rx, 8'h00);
        for (int k = 0; k < n; k++) begin
            if (sample_mid && k == 1) begin
                pulse_sample(mx, my, mz);
                m_pend = 1'b1; m_px = mx; m_py = my; m_pz = mz;
            end
            d = wbuf[k];
            spi_bits(rw ? 8'h00 : d, 8, rx);
            if (rw) begin
                e = m_regs[a];
                check_eq($sformatf("rd_%02h", a), rx, e);
                if (a == 6'h37) m_int1 = 1'b0;
            end else begin
                check_eq("wr_miso", rx, 8'h00);
                if (!m_ro(a)) begin
                    m_regs[a] = d;
                    exp_strobes++;
                    exp_wa = a;
                    exp_wd = d;
                end
            end
            if (mb) a = a + 6'd1;
        end
        check_eq("oe_active", miso_oe, 1'b1);
        check_eq("busy_active", busy, 1'b1);
        #HALF;
        CS = 1'b1;
        repeat (12) @(negedge sys_clock);
        if (m_pend) begin
            model_axis(m_px, m_py, m_pz);
            m_pend = 1'b0;
        end
        check_eq("oe_idle", miso_oe, 1'b0);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("strobes", strobe_cnt, exp_strobes);
        check_eq("wr_addr", wr_addr, exp_wa);
        check_eq("wr_data", wr_data, exp_wd);
        check_eq("int1", int1, m_int1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_miso"}, MISO, 1'b0);
        check_eq({pfx, "_oe"}, miso_oe, 1'b0);
        check_eq({pfx, "_int1"}, int1, 1'b0);
        check_eq({pfx, "_wrs"}, wr_strobe, 1'b0);
        check_eq({pfx, "_wra"}, wr_addr, 6'h00);
        check_eq({pfx, "_wrd"}, wr_data, 8'h00);
        check_eq({pfx, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] rx;
        reset_n = 1'b0;
        SCL = 1'b1; CS = 1'b1; MOSI = 1'b0;
        sample_valid = 1'b0;
        sample_x = '0; sample_y = '0; sample_z = '0;
        exp_strobes = 0;
        model_reset();
        for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
        repeat (3) @(negedge sys_clock);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        repeat (5) @(negedge sys_clock);

        // device id and reset value of bandwidth register
        do_txn(1, 0, 6'h00, 1, 0, 0, 0, 0);
        do_txn(1, 0, 6'h2C, 1, 0, 0, 0, 0);

        // write then read back
        wbuf[0] = 8'h08;
        do_txn(0, 0, 6'h2D, 1, 0, 0, 0, 0);
        do_txn(1, 0, 6'h2D, 1, 0, 0, 0, 0);

        // idle sample, burst read of all axes clears int1
        sample_idle(16'h1234, 16'hFF80, 16'h0001);
        check_eq("int1_set", int1, 1'b1);
        do_txn(1, 1, 6'h32, 6, 0, 0, 0, 0);

        // sample during burst is deferred until CS rises
        do_txn(1, 1, 6'h32, 6, 1, 16'h5555, 16'h1111, 16'h2222);
        do_txn(1, 1, 6'h32, 2, 0, 0, 0, 0);

        // address wrap in multi-byte read
        wbuf[0] = 8'hA7;
        do_txn(0, 0, 6'h3F, 1, 0, 0, 0, 0);
        do_txn(1, 1, 6'h3F, 2, 0, 0, 0, 0);

        // write to read-only axis register is ignored
        wbuf[0] = 8'h99;
        do_txn(0, 0, 6'h32, 1, 0, 0, 0, 0);
        do_txn(1, 0, 6'h32, 1, 0, 0, 0, 0);

        // aborted write after 4 data bits
        CS = 1'b0;
        #HALF;
        spi_bits(8'h2D, 8, rx);
        spi_bits(8'hFF, 4, rx);
        #HALF;
        CS = 1'b1;
        repeat (12) @(negedge sys_clock);
        check_eq("abort_strobes", strobe_cnt, exp_strobes);
        do_txn(1, 0, 6'h2D, 1, 0, 0, 0, 0);

        // randomized transactions and idle samples
        for (int t = 0; t < 30; t++) begin
            bit         rw, mb;
            logic [5:0] a;
            int         n;
            if ($urandom_range(0, 3) == 0)
                sample_idle(16'($urandom), 16'($urandom), 16'($urandom));
            rw = 1'($urandom);
            mb = 1'($urandom);
            a  = 6'($urandom);
            n  = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            do_txn(rw, mb, a, n, 0, 0, 0, 0);
        end

        // reset pulse in the middle of a read
        sample_idle(16'hBEEF, 16'hCAFE, 16'h0F0F);
        CS = 1'b0;
        #HALF;
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h00, 4, rx);
        @(negedge sys_clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        SCL = 1'b1;
        CS  = 1'b1;
        repeat (5) @(negedge sys_clock);
        reset_n = 1'b1;
        model_reset();
        repeat (5) @(negedge sys_clock);
        check_reset_outputs("postrst");
        do_txn(1, 0, 6'h2D, 1, 0, 0, 0, 0);
        do_txn(1, 1, 6'h2C, 1, 0, 0, 0, 0);
        do_txn(1, 1, 6'h36, 2, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
